// File: rtl/sc_bus_pkg.sv
// sc_bus_pkg: shared widths, FSM state and command/response payload types for sc_bus_master
package sc_bus_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic              rw;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;
endpackage

// File: rtl/sc_cmd_fifo.sv
// sc_cmd_fifo: power-of-two command FIFO; push/pop are gated internally by full/empty
module sc_cmd_fifo
    import sc_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  cmd_t din,
    input  logic pop,
    output cmd_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    // extra pointer bit tells full from empty when the indices match
    logic [AW:0] wp, rp;
    cmd_t        mem [DEPTH];

    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/sc_bus_master.sv
// sc_bus_master: queues read/write commands and runs each as one timed target-port
// transaction, returning in-order responses
module sc_bus_master
    import sc_bus_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_rw,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              bus_cs,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);
    localparam int          TW   = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    state_t        state, state_nx;
    cmd_t          cmd_in, head, op;
    rsp_t          rsp;
    logic          full, empty, pop;
    logic [TW-1:0] timer;

    assign cmd_in = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};

    sc_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // bus_ready has priority over the timeout in the same cycle
    always_comb begin
        state_nx = (state == IDLE)   ? (empty ? IDLE : ACCESS) :
                   (state == ACCESS) ? ((bus_ready || timer == TMAX) ? RESP : ACCESS) :
                                       (rsp_ready ? IDLE : RESP);
    end

    always_comb begin
        pop       = (state == IDLE) && !empty;
        bus_cs    = state == ACCESS;
        rsp_valid = state == RESP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op    <= '0;
            rsp   <= '0;
            timer <= '0;
        end else if (pop) begin
            op    <= head;
            timer <= '0;
        end else if (state == ACCESS) begin
            timer <= timer + 1'b1;
            if (bus_ready)          rsp <= '{rw: op.rw, rdata: op.rw ? bus_rdata : '0, err: 1'b0};
            else if (timer == TMAX) rsp <= '{rw: op.rw, rdata: '0, err: 1'b1};
        end
    end

    assign cmd_ready = !full;
    assign bus_rw    = op.rw;
    assign bus_addr  = op.addr;
    assign bus_wdata = op.wdata;
    assign rsp_rw    = rsp.rw;
    assign rsp_rdata = rsp.rdata;
    assign rsp_err   = rsp.err;
    assign busy      = (state != IDLE) || !empty;
endmodule

// File: tb/tb_sc_bus_master.sv
// tb_sc_bus_master: directed bench with a 2-cycle-latency RAM target model
module tb_sc_bus_master;
    logic        clk = 0, reset = 1;
    logic        cmd_valid = 0, cmd_ready, cmd_rw = 0;
    logic [15:0] cmd_addr = 0;
    logic [31:0] cmd_wdata = 0;
    logic        rsp_valid, rsp_ready = 1, rsp_rw, rsp_err;
    logic [31:0] rsp_rdata;
    logic        bus_cs, bus_rw, bus_ready = 0, busy;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata, bus_rdata = 0;

    logic [31:0] mem [64];
    logic        tgt_en = 1;
    int          cnt = 0;
    int          tests = 0, failed = 0;
    int          cs_run = 0, last_run = 0, cs_rises = 0, gap = 0, min_gap = 1000;
    logic        cs_prev = 0, seen = 0, saw_full = 0;
    logic [15:0] cs_addr = 0;
    logic [31:0] cs_wdata = 0;
    logic [33:0] rsp_q [$];

    sc_bus_master #(.CMD_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rw(rsp_rw),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .bus_cs(bus_cs), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
        .bus_rdata(bus_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // target: sees cs on one edge, pulses ready two edges later
    always @(posedge clk) begin
        if (bus_cs && tgt_en && !bus_ready) begin
            cnt <= cnt + 1;
            if (cnt == 1) begin
                bus_ready <= 1;
                bus_rdata <= mem[bus_addr[7:2]];
            end
        end else begin
            cnt       <= 0;
            bus_ready <= 0;
            if (bus_ready && bus_cs && !bus_rw) mem[bus_addr[7:2]] <= bus_wdata;
        end
    end

    always @(posedge clk) begin
        if (bus_cs) begin
            if (!cs_prev) begin
                cs_rises++;
                cs_addr  = bus_addr;
                cs_wdata = bus_wdata;
                if (seen && gap < min_gap) min_gap = gap;
                seen = 1;
            end
            cs_run++;
        end else if (cs_prev) begin
            last_run = cs_run;
            cs_run   = 0;
            gap      = 1;
        end else begin
            gap++;
        end
        cs_prev = bus_cs;
        if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_rw, rsp_err, rsp_rdata});
        if (!cmd_ready) saw_full = 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic rw, input logic [15:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1 cmd_valid = 0;
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 300 && rsp_q.size() < n; i++) @(negedge clk);
        check("rsp_count", 64'(rsp_q.size() >= n), 1);
    endtask

    task automatic pop_rsp(input string tag, input logic [33:0] exp);
        logic [33:0] r = '0;
        if (rsp_q.size() > 0) r = rsp_q.pop_front();
        check(tag, 64'(r), 64'(exp));
    endtask

    initial begin
        int k;
        logic        stable;
        logic [33:0] snap;
        int          rises;
        for (int i = 0; i < 64; i++) mem[i] = 0;
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 1);
        check("rst_rsp_valid", 64'(rsp_valid), 0);
        check("rst_bus_cs", 64'(bus_cs), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_rsp", 64'({rsp_rw, rsp_err, rsp_rdata}), 0);
        repeat (2) @(negedge clk);
        reset = 0;

        send(0, 16'h0010, 32'hDEADBEEF);
        k = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (rsp_valid) break;
        end
        check("wr_latency", 64'(k), 4);
        wait_rsp(1);
        pop_rsp("wr_rsp", {1'b0, 1'b0, 32'h0});
        check("wr_cs_len", 64'(last_run), 3);
        check("wr_cs_wdata", 64'(cs_wdata), 64'hDEADBEEF);
        check("wr_cs_addr", 64'(cs_addr), 64'h10);

        send(1, 16'h0010, 0);
        wait_rsp(1);
        pop_rsp("rd_rsp", {1'b1, 1'b0, 32'hDEADBEEF});

        repeat (3) @(negedge clk);
        saw_full = 0; min_gap = 1000;
        for (int i = 0; i < 5; i++) send(0, 16'(4 * i), 32'(i + 1));
        wait_rsp(5);
        check("burst_full", 64'(saw_full), 1);
        for (int i = 0; i < 5; i++) pop_rsp("burst_wr_rsp", {1'b0, 1'b0, 32'h0});
        check("burst_gap", 64'(min_gap >= 1), 1);
        for (int i = 0; i < 5; i++) send(1, 16'(4 * i), 0);
        wait_rsp(5);
        for (int i = 0; i < 5; i++) pop_rsp("burst_rd_rsp", {1'b1, 1'b0, 32'(i + 1)});
        repeat (3) @(negedge clk);
        check("burst_idle_busy", 64'(busy), 0);

        rsp_ready = 0;
        for (int i = 0; i < 3; i++) send(1, 16'(4 * i), 0);
        for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
        check("bp_valid_seen", 64'(rsp_valid), 1);
        snap = {rsp_rw, rsp_err, rsp_rdata};
        rises = cs_rises;
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid || {rsp_rw, rsp_err, rsp_rdata} !== snap) stable = 0;
        end
        check("bp_stable", 64'(stable), 1);
        check("bp_no_cs_rise", 64'(cs_rises), 64'(rises));
        check("bp_busy", 64'(busy), 1);
        rsp_ready = 1;
        wait_rsp(3);
        for (int i = 0; i < 3; i++) pop_rsp("bp_rsp", {1'b1, 1'b0, 32'(i + 1)});

        tgt_en = 0;
        send(0, 16'h0020, 32'h55);
        wait_rsp(1);
        pop_rsp("to_rsp", {1'b0, 1'b1, 32'h0});
        check("to_cs_len", 64'(last_run), 16);
        tgt_en = 1;
        send(0, 16'h0024, 32'hA5A5);
        send(1, 16'h0024, 0);
        wait_rsp(2);
        pop_rsp("after_to_wr", {1'b0, 1'b0, 32'h0});
        pop_rsp("after_to_rd", {1'b1, 1'b0, 32'hA5A5});

        tgt_en = 0;
        for (int i = 0; i < 3; i++) send(0, 16'(4 * i), 32'hBAD);
        for (int i = 0; i < 50 && !bus_cs; i++) @(negedge clk);
        check("rst_mid_cs_seen", 64'(bus_cs), 1);
        @(negedge clk);
        reset = 1;
        #1;
        check("rst_mid_bus_cs", 64'(bus_cs), 0);
        check("rst_mid_rsp_valid", 64'(rsp_valid), 0);
        check("rst_mid_cmd_ready", 64'(cmd_ready), 1);
        check("rst_mid_busy", 64'(busy), 0);
        @(negedge clk);
        reset = 0;
        tgt_en = 1;
        repeat (30) @(negedge clk);
        check("rst_mid_no_rsp", 64'(rsp_q.size()), 0);
        check("rst_mid_idle", 64'(busy), 0);
        check("rst_mid_mem", 64'(mem[0]), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/sc_bus_master.md
Name: sc_bus_master

Overview:
Upstream request sequencer that drives a single-slave memory-mapped target port (cs/rw/addr/wdata, ready/rdata).
- Accepts read/write commands on a valid/ready stream and buffers them in a small command FIFO.
- Runs each command as one target-port transaction with a timeout watchdog.
- Returns one in-order response per command on a valid/ready stream.
- Sits between the SystemC BFM/testbench command source and the RAM target.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of two, >=2)
TIMEOUT, 16, max cycles bus_cs stays high waiting for bus_ready before abort (>=4)
ADDR_W, 16, byte address width
DATA_W, 32, data width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_rw  in  1  1=read, 0=write
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_rw  out  1  echo of command rw
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  1=transaction timed out
bus_cs  out  1  target select
bus_rw  out  1  target direction
bus_addr  out  ADDR_W  target address
bus_wdata  out  DATA_W  target write data
bus_ready  in  1  target completion pulse
bus_rdata  in  DATA_W  target read data, valid while bus_ready=1
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset values (async, immediate):
  - All outputs 0, except cmd_ready=1.
  - FIFO emptied; FSM=IDLE.
- Reset mid-transaction:
  - Drops bus_cs at once.
  - Discards queued and in-flight commands; no response is issued for them.
- Command FIFO:
  - cmd_ready = !full.
  - Push on cmd_valid&cmd_ready; pop only by the FSM in IDLE when not empty.
  - Push and pop in the same cycle are legal at any fill level, including full (push blocked by cmd_ready) and empty (pop blocked).
  - Pointers wrap modulo CMD_DEPTH.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if FIFO not empty, pop the head into op registers (rw, addr, wdata), clear the timer, go to ACCESS.
  - ACCESS:
    - bus_cs=1; bus_rw/bus_addr/bus_wdata held stable from the op registers.
    - Timer increments each cycle.
    - If bus_ready=1: capture rdata (bus_rdata if rw=1, else 0), err=0, go to RESP.
    - Else if timer==TIMEOUT-1: rdata=0, err=1, go to RESP.
    - bus_ready and timeout in the same cycle: bus_ready wins.
  - RESP:
    - bus_cs=0; rsp_valid=1 with rsp_rw/rsp_rdata/rsp_err stable.
    - On rsp_ready go to IDLE.
- Target protocol guarantees:
  - bus_cs is low for at least one cycle between transactions (RESP lasts >=1 cycle), so the target returns to idle.
  - bus_cs is registered; it never goes high before the pop.
- bus_ready is ignored outside ACCESS, including a late pulse after a timeout abort.
- Latency against a target that raises ready 2 cycles after sampling cs:
  - Command accepted at edge T0; bus_cs high after T1; bus_ready sampled at T4; rsp_valid high after T4.
  - Throughput is one transaction per 5 cycles with rsp_ready held at 1.
- Responses are strictly in command order; at most one outstanding target transaction.
- Address is passed through unmodified; the target decodes the word index from addr[ADDR_W-1:2].
- busy = (state!=IDLE) | !empty.

Decomposition:
- Package sc_bus_pkg:
  - ADDR_W/DATA_W defaults.
  - State enum typedef (IDLE, ACCESS, RESP).
  - Packed command struct {rw, addr, wdata}.
  - Response struct {rw, rdata, err}.
- One sub-module: sc_cmd_fifo (parameterised depth, command struct payload, full/empty flags, async reset).
- FSM, timer and response register live in sc_bus_master.

Test Plan:
- Write: rw=0, addr=0x0010, wdata=0xDEADBEEF, rsp_ready=1 -> bus_cs high 3 cycles with bus_wdata=0xDEADBEEF; rsp_valid 4 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read-back: rw=1, addr=0x0010 -> rsp_rdata=0xDEADBEEF, rsp_rw=1, rsp_err=0.
- Burst: 5 back-to-back commands, CMD_DEPTH=4, writes addr 0x0..0x10 with data 1..5 -> cmd_ready drops while full; 5 in-order responses; bus_cs low >=1 cycle between transactions; read-back returns 1..5.
- Backpressure: rsp_ready=0 for 10 cycles with 3 queued -> rsp_valid and payload stable; no new bus_cs rise; responses drain in order after release.
- Timeout: bus_ready tied 0, TIMEOUT=16 -> bus_cs high exactly 16 cycles; rsp_err=1, rsp_rdata=0; next command proceeds normally.
- Reset mid-ACCESS with 2 queued: reset while bus_cs=1 -> bus_cs=0, rsp_valid=0, cmd_ready=1, busy=0 immediately; no responses for discarded commands.
